// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx, baud_gen and uart_tx.
package uart_pkg;

  localparam int unsigned UART_OVS_FACTOR = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the input through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, reset to the line's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, 3-sample mid-bit vote, LSB-first deserialise,
// valid/ready output with frame/parity error and overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVS_FACTOR = UART_OVS_FACTOR,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(OVS_FACTOR);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] T_HM1  = CW'(OVS_FACTOR / 2 - 1);
  localparam logic [CW-1:0] T_H    = CW'(OVS_FACTOR / 2);
  localparam logic [CW-1:0] T_HP1  = CW'(OVS_FACTOR / 2 + 1);
  localparam logic [CW-1:0] T_LAST = CW'(OVS_FACTOR - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  logic rx_s;

  uart_rx_state_e       state_q, state_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 done_q, done_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic vote_tick, wrap_tick, voted;

  bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign vote_tick = tick_16x && (tick_cnt_q == T_HP1);
  assign wrap_tick = tick_16x && (tick_cnt_q == T_LAST);
  assign voted     = maj3(samp_q[1], samp_q[0], rx_s);

  // Frame FSM: bit timing, sampling, voting and deserialisation.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    done_d     = 1'b0;
    stop_d     = stop_q;

    if (tick_16x && state_q != IDLE) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      if (tick_cnt_q == T_HM1) samp_d[1] = rx_s;
      if (tick_cnt_q == T_H)   samp_d[0] = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        if (tick_16x && !rx_s) begin
          state_d    = START;
          tick_cnt_d = CW'(1);
        end
      end
      START: begin
        if (vote_tick && voted) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
        end else if (wrap_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (vote_tick) shift_d = {voted, shift_q[DATA_BITS-1:1]};
        if (wrap_tick) begin
          if (bit_cnt_q == B_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                     bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (vote_tick) par_bad_d = ((^shift_q) ^ voted) != ODD;
        if (wrap_tick) state_d = STOP;
      end
      STOP: begin
        if (vote_tick) begin
          done_d     = 1'b1;
          stop_d     = voted;
          state_d    = voted ? IDLE : BREAK;
          tick_cnt_d = '0;
        end
      end
      BREAK: begin
        tick_cnt_d = '0;
        if (tick_16x && rx_s) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
      end
    endcase
  end

  // Output register: deliver completed frames or flag an overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        frame_err_d  = !stop_q;
        parity_err_d = par_bad_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '1;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      done_q       <= 1'b0;
      stop_q       <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      done_q       <= done_d;
      stop_q       <= stop_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 instance (a) and 8E1 instance (b).
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_16x = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rx_ready_a = 1'b1, rx_ready_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       frame_err_a, frame_err_b;
  logic       parity_err_a, parity_err_b;
  logic       overrun_a, overrun_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_errs   = 0;

  // Handshake monitors.
  int         acc_a = 0, acc_b = 0, ovr_a = 0;
  logic [7:0] last_a = '0, last_b = '0;
  logic       fe_a = 1'b0, pe_a = 1'b0, pe_b = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVS_FACTOR(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick_16x), .rx(rx_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a),
    .busy(busy_a)
  );

  uart_rx #(.DATA_BITS(8), .OVS_FACTOR(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick_16x), .rx(rx_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b),
    .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Oversampling strobe: one clk high every TICK_DIV clks.
  initial begin
    forever begin
      step(TICK_DIV - 1);
      tick_16x = 1'b1;
      step(1);
      tick_16x = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_valid_a && rx_ready_a) begin
      acc_a++;
      last_a = rx_data_a;
      fe_a   = frame_err_a;
      pe_a   = parity_err_a;
    end
    if (rx_valid_b && rx_ready_b) begin
      acc_b++;
      last_b = rx_data_b;
      pe_b   = parity_err_b;
    end
    if (overrun_a) ovr_a++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive n bits LSB first on line a (sel=0) or b (sel=1).
  task automatic send_bits(input int sel, input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_a = f[i];
      else          rx_b = f[i];
      step(BIT_CLKS);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop);
    logic [10:0] f;
    f = {1'b1, stop, d, 1'b0};
    send_bits(0, f, 10);
  endtask

  task automatic send_b(input logic [7:0] d, input logic par);
    logic [10:0] f;
    f = {1'b1, par, d, 1'b0};
    send_bits(1, f, 11);
  endtask

  int acc_snap;

  initial begin
    // Reset state
    step(5);
    check("rst_valid", 32'(rx_valid_a), 32'd0);
    check("rst_data", 32'(rx_data_a), 32'h00);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ferr", 32'(frame_err_a), 32'd0);
    check("rst_ovr", 32'(overrun_a), 32'd0);
    reset_n = 1'b1;
    step(20);

    // 0x55 8N1
    send_a(8'h55, 1'b1);
    step(BIT_CLKS);
    check("f55_count", 32'(acc_a), 32'd1);
    check("f55_data", 32'(last_a), 32'h55);
    check("f55_ferr", 32'(fe_a), 32'd0);
    check("f55_perr", 32'(pe_a), 32'd0);
    check("f55_ovr", 32'(ovr_a), 32'd0);

    // Glitch: low for 4 ticks
    rx_a = 1'b0;
    step(4 * TICK_DIV);
    check("glitch_busy_hi", 32'(busy_a), 32'd1);
    rx_a = 1'b1;
    step(20 * TICK_DIV);
    check("glitch_busy_lo", 32'(busy_a), 32'd0);
    check("glitch_count", 32'(acc_a), 32'd1);

    // 0xA3 with stop 0, line held low 3 more bit times
    send_bits(0, {1'b0, 1'b0, 8'hA3, 1'b0}, 10);
    rx_a = 1'b0;
    step(3 * BIT_CLKS);
    check("brk_count", 32'(acc_a), 32'd2);
    check("brk_data", 32'(last_a), 32'hA3);
    check("brk_ferr", 32'(fe_a), 32'd1);
    check("brk_busy", 32'(busy_a), 32'd1);
    rx_a = 1'b1;
    step(4 * TICK_DIV);
    check("brk_exit", 32'(busy_a), 32'd0);
    step(2 * BIT_CLKS);
    check("brk_no_more", 32'(acc_a), 32'd2);

    // Even parity on b: 0x07 has odd weight
    send_b(8'h07, 1'b0);
    step(BIT_CLKS);
    check("par0_data", 32'(last_b), 32'h07);
    check("par0_perr", 32'(pe_b), 32'd1);
    send_b(8'h07, 1'b1);
    step(BIT_CLKS);
    check("par1_count", 32'(acc_b), 32'd2);
    check("par1_perr", 32'(pe_b), 32'd0);

    // Overrun: consumer stalled across two frames
    rx_ready_a = 1'b0;
    send_a(8'h11, 1'b1);
    send_a(8'h22, 1'b1);
    step(BIT_CLKS / 2);
    check("ovr_valid", 32'(rx_valid_a), 32'd1);
    check("ovr_data", 32'(rx_data_a), 32'h11);
    check("ovr_pulse", 32'(ovr_a), 32'd1);
    acc_snap = acc_a;
    rx_ready_a = 1'b1;
    step(1);
    check("ovr_acc_data", 32'(last_a), 32'h11);
    check("ovr_valid_fall", 32'(rx_valid_a), 32'd0);
    step(2 * BIT_CLKS);
    check("ovr_acc_count", 32'(acc_a - acc_snap), 32'd1);

    // Reset during data bit 4 of 0xFF
    rx_a = 1'b0;
    step(BIT_CLKS);
    rx_a = 1'b1;
    step(4 * BIT_CLKS + BIT_CLKS / 2);
    check("mid_busy", 32'(busy_a), 32'd1);
    check("mid_hold_data", 32'(rx_data_a), 32'h11);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_data", 32'(rx_data_a), 32'h00);
    check("mid_rst_valid", 32'(rx_valid_a), 32'd0);
    step(10);
    reset_n = 1'b1;
    step(20);
    acc_snap = acc_a;
    send_a(8'h3C, 1'b1);
    step(BIT_CLKS);
    check("post_rst_count", 32'(acc_a - acc_snap), 32'd1);
    check("post_rst_data", 32'(last_a), 32'h3C);
    check("post_rst_ferr", 32'(fe_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive front end, directly downstream of baud_gen. Consumes baud_gen's tick_16x oversampling strobe and the asynchronous serial input. Detects start bits, majority-votes each bit at mid-bit, and deserialises the frame LSB first. Presents the byte plus error status on a valid/ready interface toward the RX FIFO / host logic.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVS_FACTOR, 16, ticks per bit; must equal baud_gen OVS_FACTOR; power of 2, >= 8
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
tick_16x  in  1  one-clk strobe from baud_gen, OVS_FACTOR per bit period
rx  in  1  raw serial line, asynchronous, idle high
rx_data  out  DATA_BITS  received word, LSB = first bit on the line
rx_valid  out  1  rx_data and status are valid; held until accepted
rx_ready  in  1  consumer accepts when rx_valid && rx_ready
frame_err  out  1  stop bit sampled 0; qualified by rx_valid
parity_err  out  1  parity mismatch; qualified by rx_valid; 0 when PARITY_EN = 0
overrun  out  1  one-clk pulse: a frame completed while the output was still held and was dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE; synchroniser flops = 1; counters = 0.
  - rx_data = 0; rx_valid = 0; frame_err = 0; parity_err = 0; overrun = 0; busy = 0.
  - Reset mid-frame abandons the frame with no output.
- rx passes through a 2-FF synchroniser (reset value 1); all decisions use the synchronised rx_s. Latency is 2 clk.
- tick_cnt (clog2(OVS_FACTOR) bits) advances only on tick_16x and wraps OVS_FACTOR-1 -> 0. All state actions occur only on tick_16x cycles.
- Voting:
  - Samples are taken at tick_cnt = H-1, H, H+1, where H = OVS_FACTOR/2.
  - Bit value = majority of the 3 samples, decided at tick_cnt = H+1.
- States:
  - IDLE: on tick with rx_s = 0 -> START, tick_cnt = 1 (counts the detecting tick as 0).
  - START: at the vote, result 1 -> IDLE (false start, no flags, no output); result 0 -> stay.
    - At tick_cnt wrap -> DATA, bit_cnt = 0.
  - DATA: at each vote, shift the bit into shift_reg MSB and shift right (LSB first).
    - At wrap: bit_cnt == DATA_BITS-1 -> PARITY if PARITY_EN else STOP; otherwise bit_cnt++.
  - PARITY: at the vote, par_bad = (XOR of data ^ voted bit) != PARITY_ODD. At wrap -> STOP.
  - STOP: at the vote, complete the frame (below).
    - Voted 1 -> IDLE immediately at mid-stop, which allows resync to a back-to-back start.
    - Voted 0 -> BREAK.
  - BREAK: wait for any tick with rx_s = 1 -> IDLE. This prevents a held-low line from producing repeated frames.
- Frame completion (the cycle after the STOP vote tick):
  - If !rx_valid, or rx_valid && rx_ready in that same cycle: load rx_data = shift_reg, frame_err = !stop, parity_err = par_bad, rx_valid = 1.
  - Otherwise: keep the old word and flags, pulse overrun for 1 clk, discard the new word.
- Handshake:
  - rx_valid falls the cycle after rx_valid && rx_ready, unless a simultaneous completion reloads it.
  - rx_data, frame_err and parity_err are stable while rx_valid = 1.
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_e {IDLE, START, DATA, PARITY, STOP, BREAK};
  - the default OVS_FACTOR and DATA_BITS constants, shared with baud_gen and the future uart_tx.
- One sub-module: bit_sync, a 2-FF synchroniser with parameterised reset value, async active-low reset. It is reusable for CTS/RTS.

Test Plan:
- baud_gen (115200, 100 MHz) drives tick_16x; rx carries frame 0x55, 8N1, rx_ready = 1 -> exactly one rx_valid with rx_data = 0x55, frame_err = 0, parity_err = 0, overrun = 0.
- rx low for 4 ticks then high (glitch) -> START exits to IDLE at the vote; no rx_valid; busy drops within OVS_FACTOR ticks.
- Frame 0xA3 with stop bit 0, then line held low for 3 bit times -> one rx_valid with rx_data = 0xA3 and frame_err = 1. State stays in BREAK until rx = 1, and no further frames are produced.
- PARITY_EN = 1, PARITY_ODD = 0, frame 0x07 with parity bit 0 -> parity_err = 1. Same frame with parity bit 1 -> parity_err = 0.
- rx_ready = 0, frames 0x11 then 0x22 back-to-back -> rx_data holds 0x11 and overrun pulses 1 clk at the second completion. After ready, rx_valid falls and 0x22 is never presented.
- reset_n asserted during DATA bit 4 of 0xFF -> all outputs 0 immediately; after release, the next 0x3C frame is received correctly.
